insn_fetch_queue: RTL and testbench
===================================

INSN_FETCH_QUEUE -- requirements
Module: insn_fetch_queue

Interface
REQ-001 SHALL have parameter LG_DEPTH, default 3, meaning log2 of entry count (DEPTH = 2**LG_DEPTH = 8).
REQ-002 SHALL have parameter AF_THRESH, default 6, meaning occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, meaning discard all entries (pipeline redirect).
REQ-006 SHALL have port push_valid, input, 1, meaning fetch presents an instruction.
REQ-007 SHALL have port push_ready, output, 1, meaning the queue accepts a push this cycle.
REQ-008 SHALL have port push_insn, input, 32, meaning the raw RISC-V instruction word.
REQ-009 SHALL have port push_pc, input, `M_WIDTH, meaning the instruction PC.
REQ-010 SHALL have port push_pred, input, 1, meaning the branch-taken prediction.
REQ-011 SHALL have port push_pht_idx, input, `LG_PHT_SZ, meaning the PHT index used for the prediction.
REQ-012 SHALL have port push_pred_target, input, `M_WIDTH, meaning the predicted target (jalr/ret).
REQ-013 SHALL have port pop_valid, output, 1, meaning head entry valid for decode.
REQ-014 SHALL have port pop_ready, input, 1, meaning decode consumes the head this cycle.
REQ-015 SHALL have ports pop_insn/pop_pc/pop_pred/pop_pht_idx/pop_pred_target, output, widths as push_*, meaning head-entry fields.
REQ-016 SHALL have port occupancy, output, LG_DEPTH+1, meaning current entry count 0..DEPTH.
REQ-017 SHALL have port almost_full, output, 1, meaning occupancy >= AF_THRESH.

Function
REQ-018 SHALL be a circular buffer: head and tail pointers of LG_DEPTH bits plus one wrap bit each; full = pointers equal with wrap bits differing, empty = pointers and wrap bits equal.
REQ-019 SHALL drive push_ready = !full, from registered state only (no combinational dependence on pop_ready).
REQ-020 SHALL drive pop_valid = !empty; pop_* fields read combinationally from the head entry; fields undefined-but-stable when empty are permitted and SHALL be ignored by consumers.
REQ-021 SHALL accept a push when push_valid & push_ready: write entry at tail, advance tail (wrapping DEPTH-1 -> 0, toggling wrap bit).
REQ-022 SHALL perform a pop when pop_valid & pop_ready: advance head identically.
REQ-023 SHALL support push and pop in the same cycle; occupancy unchanged; when full, push is refused (push_ready=0) even if a pop occurs.
REQ-024 SHALL NOT bypass: a push into an empty queue becomes visible on pop_valid the following cycle (latency 1).
REQ-025 SHALL, on flush, set head = tail = 0, wrap bits 0, occupancy 0 next cycle; flush overrides any simultaneous push or pop (both dropped).
REQ-026 SHALL update occupancy as a registered counter: +1 push-only, -1 pop-only, unchanged otherwise; SHALL always equal tail-minus-head distance.
REQ-027 SHALL ignore pop_ready when empty and push_valid when full (no pointer movement, no corruption).
REQ-028 SHALL preserve entry field order and values bit-exactly (FIFO order, no reordering).
REQ-029 SHALL NOT reset storage array contents; only pointers, wrap bits and occupancy are reset.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, set pointers and wrap bits to 0 and occupancy to 0; reset overrides flush, push and pop.
REQ-031 SHALL present after reset: pop_valid=0, push_ready=1, occupancy=0, almost_full=0.
REQ-032 SHALL, on reset asserted mid-operation with entries held, discard all entries; first pop after reset returns only data pushed after reset deassertion.

Verification
REQ-033 Push insn 0x00000013 pc 0x1000 into empty queue -> pop_valid=0 same cycle, pop_valid=1 next cycle, pop_insn=0x00000013, pop_pc=0x1000, occupancy=1.
REQ-034 Push 8 entries pc 0x1000..0x101c with pop_ready=0 -> push_ready=0 after the 8th, almost_full=1 from occupancy 6, 9th push ignored; drain returns pcs 0x1000..0x101c in order.
REQ-035 Full queue, push_valid=1 and pop_ready=1 same cycle -> pop accepted, push refused, occupancy 7; next cycle push accepted, occupancy 8.
REQ-036 Occupancy 4, flush=1 with push_valid=1 and pop_ready=1 -> next cycle occupancy=0, pop_valid=0, pushed entry not present.
REQ-037 Run 20 interleaved push/pop cycles crossing wrap-around twice -> pop stream equals push stream exactly (insn, pc, pred, pht_idx, pred_target).
REQ-038 Occupancy 5, reset=1 for one cycle with push_valid=1 -> occupancy=0, pop_valid=0, push_ready=1 after reset.

Source files
------------

// File: rtl/insn_fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode.
// Ports: clk, reset; flush; push_* (fetch side); pop_* (decode side); occupancy, almost_full.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif

module insn_fetch_queue #(
  parameter int LG_DEPTH  = 3,
  parameter int AF_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [31:0]           push_insn,
  input  logic [`M_WIDTH-1:0]   push_pc,
  input  logic                  push_pred,
  input  logic [`LG_PHT_SZ-1:0] push_pht_idx,
  input  logic [`M_WIDTH-1:0]   push_pred_target,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [31:0]           pop_insn,
  output logic [`M_WIDTH-1:0]   pop_pc,
  output logic                  pop_pred,
  output logic [`LG_PHT_SZ-1:0] pop_pht_idx,
  output logic [`M_WIDTH-1:0]   pop_pred_target,
  output logic [LG_DEPTH:0]     occupancy,
  output logic                  almost_full
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] AF = AF_THRESH[LG_DEPTH:0];
  localparam logic [LG_DEPTH:0] ONE = {{LG_DEPTH{1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0]           insn;
    logic [`M_WIDTH-1:0]   pc;
    logic                  pred;
    logic [`LG_PHT_SZ-1:0] pht_idx;
    logic [`M_WIDTH-1:0]   target;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [LG_DEPTH-1:0] head_q, head_d;
  logic [LG_DEPTH-1:0] tail_q, tail_d;
  logic                hwrap_q, hwrap_d;
  logic                twrap_q, twrap_d;
  logic [LG_DEPTH:0]   occ_q, occ_d;

  logic full, empty, do_push, do_pop;

  assign full  = (head_q == tail_q) && (hwrap_q != twrap_q);
  assign empty = (head_q == tail_q) && (hwrap_q == twrap_q);

  assign push_ready = !full;
  assign pop_valid  = !empty;

  assign do_push = push_valid && !full;
  assign do_pop  = pop_ready && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    hwrap_d = hwrap_q;
    twrap_d = twrap_q;
    occ_d   = occ_q;
    if (flush) begin
      // Redirect: everything in flight is stale, drop this cycle's traffic too.
      head_d  = '0;
      tail_d  = '0;
      hwrap_d = 1'b0;
      twrap_d = 1'b0;
      occ_d   = '0;
    end else begin
      if (do_push) begin
        tail_d = tail_q + 1'b1;
        if (&tail_q) twrap_d = !twrap_q;
      end
      if (do_pop) begin
        head_d = head_q + 1'b1;
        if (&head_q) hwrap_d = !hwrap_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + ONE;
        2'b01:   occ_d = occ_q - ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      hwrap_q <= 1'b0;
      twrap_q <= 1'b0;
      occ_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      hwrap_q <= hwrap_d;
      twrap_q <= twrap_d;
      occ_q   <= occ_d;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem_q[tail_q] <= '{insn:    push_insn,
                         pc:      push_pc,
                         pred:    push_pred,
                         pht_idx: push_pht_idx,
                         target:  push_pred_target};
    end
  end

  assign pop_insn        = mem_q[head_q].insn;
  assign pop_pc          = mem_q[head_q].pc;
  assign pop_pred        = mem_q[head_q].pred;
  assign pop_pht_idx     = mem_q[head_q].pht_idx;
  assign pop_pred_target = mem_q[head_q].target;

  assign occupancy   = occ_q;
  assign almost_full = (occ_q >= AF);

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue.
// Each task drives one scenario and checks its own results.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif

module tb_insn_fetch_queue;

  logic                  clk = 1'b0;
  logic                  reset, flush;
  logic                  push_valid, push_ready;
  logic [31:0]           push_insn;
  logic [`M_WIDTH-1:0]   push_pc;
  logic                  push_pred;
  logic [`LG_PHT_SZ-1:0] push_pht_idx;
  logic [`M_WIDTH-1:0]   push_pred_target;
  logic                  pop_valid, pop_ready;
  logic [31:0]           pop_insn;
  logic [`M_WIDTH-1:0]   pop_pc;
  logic                  pop_pred;
  logic [`LG_PHT_SZ-1:0] pop_pht_idx;
  logic [`M_WIDTH-1:0]   pop_pred_target;
  logic [3:0]            occupancy;
  logic                  almost_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  insn_fetch_queue #(.LG_DEPTH(3), .AF_THRESH(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_insn(push_insn), .push_pc(push_pc),
    .push_pred(push_pred), .push_pht_idx(push_pht_idx),
    .push_pred_target(push_pred_target),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_insn(pop_insn), .pop_pc(pop_pc),
    .pop_pred(pop_pred), .pop_pht_idx(pop_pht_idx),
    .pop_pred_target(pop_pred_target),
    .occupancy(occupancy), .almost_full(almost_full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 0; pop_ready = 0; flush = 0; reset = 0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      push_valid = 1;
      push_insn = 32'h13 + i;
      push_pc = base + 4 * i;
      push_pred = 0; push_pht_idx = 0; push_pred_target = 0;
      step();
    end
    push_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    n_cmp++;
    if (pop_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_pop_valid got %b want 0", pop_valid);
    end
    n_cmp++;
    if (push_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_push_ready got %b want 1", push_ready);
    end
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_err++; $display("FAIL rst_occ got %0d want 0", occupancy);
    end
    n_cmp++;
    if (almost_full !== 1'b0) begin
      n_err++; $display("FAIL rst_af got %b want 0", almost_full);
    end
  endtask

  task automatic test_single();
    push_valid = 1; push_insn = 32'h00000013; push_pc = 32'h1000;
    push_pred = 0; push_pht_idx = 0; push_pred_target = 0;
    #1;
    n_cmp++;
    if (pop_valid !== 1'b0) begin
      n_err++; $display("FAIL single_bypass got %b want 0", pop_valid);
    end
    step();
    push_valid = 0;
    n_cmp++;
    if (pop_valid !== 1'b1) begin
      n_err++; $display("FAIL single_valid got %b want 1", pop_valid);
    end
    n_cmp++;
    if (pop_insn !== 32'h13) begin
      n_err++; $display("FAIL single_insn got %h want 00000013", pop_insn);
    end
    n_cmp++;
    if (pop_pc !== 32'h1000) begin
      n_err++; $display("FAIL single_pc got %h want 1000", pop_pc);
    end
    n_cmp++;
    if (occupancy !== 4'd1) begin
      n_err++; $display("FAIL single_occ got %0d want 1", occupancy);
    end
    pop_ready = 1;
    step();
    pop_ready = 0;
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_err++; $display("FAIL single_pop_occ got %0d want 0", occupancy);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      push_valid = 1; push_insn = 32'h13 + i; push_pc = 32'h1000 + 4 * i;
      step();
      n_cmp++;
      if (occupancy !== 4'(i + 1)) begin
        n_err++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occupancy, i + 1);
      end
      n_cmp++;
      if (almost_full !== (i + 1 >= 6)) begin
        n_err++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, i + 1 >= 6);
      end
      n_cmp++;
      if (push_ready !== (i + 1 < 8)) begin
        n_err++; $display("FAIL fill_rdy[%0d] got %b want %b", i, push_ready, i + 1 < 8);
      end
    end
    push_pc = 32'hdead; push_insn = 32'hdead;
    step();
    push_valid = 0;
    n_cmp++;
    if (occupancy !== 4'd8) begin
      n_err++; $display("FAIL ninth_occ got %0d want 8", occupancy);
    end
    pop_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (pop_valid !== 1'b1 || pop_pc !== 32'h1000 + 4 * i) begin
        n_err++;
        $display("FAIL drain_pc[%0d] got v=%b %h want v=1 %h", i, pop_valid, pop_pc, 32'h1000 + 4 * i);
      end
      step();
    end
    pop_ready = 0;
    n_cmp++;
    if (occupancy !== 4'd0 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_empty got occ=%0d v=%b want 0 0", occupancy, pop_valid);
    end
  endtask

  task automatic test_full_pushpop();
    push_n(8, 32'h2000);
    push_valid = 1; push_pc = 32'h3000; pop_ready = 1;
    #1;
    n_cmp++;
    if (push_ready !== 1'b0) begin
      n_err++; $display("FAIL full_rdy got %b want 0", push_ready);
    end
    step();
    pop_ready = 0;
    n_cmp++;
    if (occupancy !== 4'd7 || pop_pc !== 32'h2004) begin
      n_err++; $display("FAIL full_pp got occ=%0d pc=%h want 7 2004", occupancy, pop_pc);
    end
    step();
    push_valid = 0;
    n_cmp++;
    if (occupancy !== 4'd8) begin
      n_err++; $display("FAIL full_refill got %0d want 8", occupancy);
    end
    pop_ready = 1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      exp = (i == 7) ? 32'h3000 : 32'h2004 + 4 * i;
      n_cmp++;
      if (pop_pc !== exp) begin
        n_err++; $display("FAIL full_drain[%0d] got %h want %h", i, pop_pc, exp);
      end
      step();
    end
    pop_ready = 0;
  endtask

  task automatic test_flush();
    push_n(4, 32'h4000);
    flush = 1; push_valid = 1; push_pc = 32'h4100; pop_ready = 1;
    step();
    idle();
    n_cmp++;
    if (occupancy !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush got occ=%0d v=%b r=%b want 0 0 1", occupancy, pop_valid, push_ready);
    end
    push_n(1, 32'h5000);
    n_cmp++;
    if (pop_pc !== 32'h5000 || occupancy !== 4'd1) begin
      n_err++; $display("FAIL flush_after got pc=%h occ=%0d want 5000 1", pop_pc, occupancy);
    end
    pop_ready = 1;
    step();
    pop_ready = 0;
  endtask

  task automatic test_wrap();
    logic [112:0] q[$];
    logic [112:0] e, got;
    for (int i = 0; i < 20; i++) begin
      e = {32'hA5000000 ^ (32'(i) * 32'h01010101), 32'h8000 + 32'(4 * i),
           1'(i), 16'(i * 37), 32'hC000 + 32'(i * 8)};
      push_valid = 1;
      {push_insn, push_pc, push_pred, push_pht_idx, push_pred_target} = e;
      pop_ready = (i % 3 != 0);
      #1;
      n_cmp++;
      if (push_ready !== (q.size() < 8) || pop_valid !== (q.size() > 0)) begin
        n_err++;
        $display("FAIL wrap_hs[%0d] got r=%b v=%b qsize=%0d", i, push_ready, pop_valid, q.size());
      end
      if (pop_ready && q.size() > 0) begin
        got = {pop_insn, pop_pc, pop_pred, pop_pht_idx, pop_pred_target};
        n_cmp++;
        if (got !== q[0]) begin
          n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i, got, q[0]);
        end
        void'(q.pop_front());
      end
      if (q.size() < 8) q.push_back(e);
      step();
      n_cmp++;
      if (occupancy !== 4'(q.size())) begin
        n_err++; $display("FAIL wrap_occ[%0d] got %0d want %0d", i, occupancy, q.size());
      end
    end
    push_valid = 0; pop_ready = 1;
    while (q.size() > 0) begin
      got = {pop_insn, pop_pc, pop_pred, pop_pht_idx, pop_pred_target};
      n_cmp++;
      if (pop_valid !== 1'b1 || got !== q[0]) begin
        n_err++; $display("FAIL wrap_tail got v=%b %h want %h", pop_valid, got, q[0]);
      end
      void'(q.pop_front());
      step();
    end
    pop_ready = 0;
    n_cmp++;
    if (pop_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_empty got %b want 0", pop_valid);
    end
  endtask

  task automatic test_reset_mid();
    push_n(5, 32'h6000);
    reset = 1; push_valid = 1; push_pc = 32'h6100;
    step();
    idle();
    n_cmp++;
    if (occupancy !== 4'd0 || pop_valid !== 1'b0 ||
        push_ready !== 1'b1 || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid got occ=%0d v=%b r=%b af=%b want 0 0 1 0",
               occupancy, pop_valid, push_ready, almost_full);
    end
    push_n(1, 32'h7000);
    n_cmp++;
    if (pop_pc !== 32'h7000 || occupancy !== 4'd1) begin
      n_err++; $display("FAIL rstmid_after got pc=%h occ=%0d want 7000 1", pop_pc, occupancy);
    end
  endtask

  initial begin
    idle();
    push_insn = 0; push_pc = 0; push_pred = 0;
    push_pht_idx = 0; push_pred_target = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pushpop();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
